// File: rtl/i_decode.sv
`default_nettype none
// ============================================================================
//  Module      : i_decode
//  Description : LEGv8 instruction decode stage. Produces datapath control
//                signals, the sign-extended immediate and two register-file
//                read ports, all combinationally from the instruction. The
//                32 x WORD register file is written on the rising clock edge.
//                X31 (XZR) always reads as zero.
//  Config      : REGFILE_INIT_EN - when defined, reset loads Xn with n
//                (n = 0..30). Otherwise reset clears every register.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_decode #(
    parameter int INSTR_LEN = 32,
    parameter int WORD      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_LEN-1:0] instruction_in,
    input  logic [WORD-1:0]      write_data_in,
    output logic [10:0]          opcode,
    output logic [WORD-1:0]      sign_extended_output,
    output logic                 reg2_loc,
    output logic                 uncondbranch,
    output logic                 branch,
    output logic                 mem_read,
    output logic                 mem_to_reg,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic [1:0]           alu_op,
    output logic [WORD-1:0]      read_data1,
    output logic [WORD-1:0]      read_data2
);

    // Full 11-bit opcodes
    localparam logic [10:0] c_op_add  = 11'b10001011000;
    localparam logic [10:0] c_op_sub  = 11'b11001011000;
    localparam logic [10:0] c_op_and  = 11'b10001010000;
    localparam logic [10:0] c_op_orr  = 11'b10101010000;
    localparam logic [10:0] c_op_ldur = 11'b11111000010;
    localparam logic [10:0] c_op_stur = 11'b11111000000;
    // Short opcodes: CBZ uses opcode[10:3], B uses opcode[10:5]
    localparam logic [7:0]  c_op_cbz  = 8'b10110100;
    localparam logic [5:0]  c_op_b    = 6'b000101;
    // Zero register index
    localparam logic [4:0]  c_xzr     = 5'd31;
    localparam int          c_nregs   = 32;

    logic            w_is_rtype;
    logic            w_is_ldur;
    logic            w_is_stur;
    logic            w_is_cbz;
    logic            w_is_b;
    logic [4:0]      w_rn;
    logic [4:0]      w_rm;
    logic [4:0]      w_rd;
    logic [4:0]      w_rb;
    logic [WORD-1:0] r_regs [0:c_nregs-1];

    assign opcode = instruction_in[31:21];

    // Instruction class detection
    assign w_is_rtype = (opcode == c_op_add) || (opcode == c_op_sub) ||
                        (opcode == c_op_and) || (opcode == c_op_orr);
    assign w_is_ldur  = (opcode == c_op_ldur);
    assign w_is_stur  = (opcode == c_op_stur);
    assign w_is_cbz   = (opcode[10:3] == c_op_cbz);
    assign w_is_b     = (opcode[10:5] == c_op_b);

    // Control signal generation; unknown opcodes leave everything at zero
    always_comb begin
        reg2_loc     = 1'b0;
        uncondbranch = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        alu_op       = 2'b00;
        if (w_is_rtype) begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
        end else if (w_is_ldur) begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
        end else if (w_is_stur) begin
            reg2_loc  = 1'b1;
            alu_src   = 1'b1;
            mem_write = 1'b1;
        end else if (w_is_cbz) begin
            reg2_loc = 1'b1;
            branch   = 1'b1;
            alu_op   = 2'b01;
        end else if (w_is_b) begin
            uncondbranch = 1'b1;
        end
    end

    // Immediate extraction and sign extension by instruction format
    always_comb begin
        sign_extended_output = '0;
        if (w_is_ldur || w_is_stur) begin
            sign_extended_output = {{(WORD-9){instruction_in[20]}},
                                    instruction_in[20:12]};
        end else if (w_is_cbz) begin
            sign_extended_output = {{(WORD-19){instruction_in[23]}},
                                    instruction_in[23:5]};
        end else if (w_is_b) begin
            sign_extended_output = {{(WORD-26){instruction_in[25]}},
                                    instruction_in[25:0]};
        end
    end

    // Register addresses; stores and CBZ read their second operand from Rt
    assign w_rn = instruction_in[9:5];
    assign w_rm = instruction_in[20:16];
    assign w_rd = instruction_in[4:0];
    assign w_rb = reg2_loc ? w_rd : w_rm;

    // Asynchronous reads with XZR forced to zero; no write-to-read bypass
    assign read_data1 = (w_rn == c_xzr) ? '0 : r_regs[w_rn];
    assign read_data2 = (w_rb == c_xzr) ? '0 : r_regs[w_rb];

    // Register file update; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_nregs; i++) begin
`ifdef REGFILE_INIT_EN
                r_regs[i] <= (i == c_nregs - 1) ? '0 : WORD'(i);
`else
                r_regs[i] <= '0;
`endif
            end
        end else if (reg_write && (w_rd != c_xzr)) begin
            r_regs[w_rd] <= write_data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_decode
//  Description : Self-checking bench for i_decode. Directed LEGv8 cases plus
//                randomized instructions compared against an instruction-
//                level reference model of the decoder and register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_in = '0;
    logic [63:0] write_data_in = '0;
    logic [10:0] opcode;
    logic [63:0] sign_extended_output;
    logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [63:0] read_data1, read_data2;

    int n_pass  = 0;
    int n_total = 0;

    // Reference register state
    logic [63:0] mregs [32];

    typedef struct packed {
        logic [9:0]  ctrl;   // {r2l,ub,br,mr,m2r,mw,as,rw,alu_op[1:0]}
        logic [63:0] sext;
    } exp_t;

    i_decode #(.INSTR_LEN(32), .WORD(64)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_in       (instruction_in),
        .write_data_in        (write_data_in),
        .opcode               (opcode),
        .sign_extended_output (sign_extended_output),
        .reg2_loc             (reg2_loc),
        .uncondbranch         (uncondbranch),
        .branch               (branch),
        .mem_read             (mem_read),
        .mem_to_reg           (mem_to_reg),
        .mem_write            (mem_write),
        .alu_src              (alu_src),
        .reg_write            (reg_write),
        .alu_op               (alu_op),
        .read_data1           (read_data1),
        .read_data2           (read_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] reset_val(int n);
`ifdef REGFILE_INIT_EN
        return (n == 31) ? 64'd0 : 64'(n);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] mread(logic [4:0] idx);
        return (idx == 5'd31) ? 64'd0 : mregs[idx];
    endfunction

    // Interpret a two's-complement field of 'bits' width as a signed number
    function automatic logic [63:0] sx(longint raw, int bits);
        longint v;
        v = raw;
        if (v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 64'(v);
    endfunction

    // Instruction-level decode reference
    function automatic exp_t ref_decode(logic [31:0] ins);
        exp_t e;
        logic [10:0] op;
        op = ins[31:21];
        e = '0;
        if (op inside {11'b10001011000, 11'b11001011000,
                       11'b10001010000, 11'b10101010000}) begin
            e.ctrl = 10'b00000001_10;
        end else if (op == 11'b11111000010) begin
            e.ctrl = 10'b00011011_00;
            e.sext = sx(longint'(ins[20:12]), 9);
        end else if (op == 11'b11111000000) begin
            e.ctrl = 10'b10000110_00;
            e.sext = sx(longint'(ins[20:12]), 9);
        end else if (op[10:3] == 8'b10110100) begin
            e.ctrl = 10'b10100000_01;
            e.sext = sx(longint'(ins[23:5]), 19);
        end else if (op[10:5] == 6'b000101) begin
            e.ctrl = 10'b01000000_00;
            e.sext = sx(longint'(ins[25:0]), 26);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    // Apply one instruction for one cycle: check outputs before the edge,
    // then advance the model as the edge will.
    task automatic step(input string tag, input logic [31:0] ins,
                        input logic [63:0] wd, input logic rst);
        exp_t e;
        logic [4:0] rb;
        @(negedge clk);
        instruction_in = ins;
        write_data_in  = wd;
        reset          = rst;
        #1;
        e  = ref_decode(ins);
        rb = e.ctrl[9] ? ins[4:0] : ins[20:16];
        check({tag, ".opcode"}, 64'(opcode), 64'(ins[31:21]));
        check({tag, ".ctrl"}, 64'({reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
                                   mem_write, alu_src, reg_write, alu_op}), 64'(e.ctrl));
        check({tag, ".sext"}, sign_extended_output, e.sext);
        check({tag, ".rd1"}, read_data1, mread(ins[9:5]));
        check({tag, ".rd2"}, read_data2, mread(rb));
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = reset_val(i);
        end else if (e.ctrl[2] && ins[4:0] != 5'd31) begin
            mregs[ins[4:0]] = wd;
        end
    endtask

    function automatic logic [31:0] rtype(logic [10:0] op, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] dtype(logic [10:0] op, logic [8:0] imm, logic [4:0] rn, logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [10:0] ops [6];
        int cls;
        ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                11'b10101010000, 11'b11111000010, 11'b11111000000};
        cls = $urandom_range(0, 8);
        if (cls < 4)
            return rtype(ops[cls], 5'($urandom), 5'($urandom), 5'($urandom));
        else if (cls < 6)
            return dtype(ops[cls], 9'($urandom), 5'($urandom), 5'($urandom));
        else if (cls == 6)
            return {8'b10110100, 19'($urandom), 5'($urandom)};
        else if (cls == 7)
            return {6'b000101, 26'($urandom)};
        else
            return 32'($urandom);
    endfunction

    initial begin
        logic [31:0] ins;
        // Power-up reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) mregs[i] = reset_val(i);

        // Reset state of every register, read through both ports
        for (int i = 0; i < 32; i += 2)
            step("reset_rd", {11'd0, 5'(i + 1), 6'd0, 5'(i), 5'd0}, 64'd0, 1'b0);

        // LDUR X9,[X22,#64] with write-back of 0x1234
        step("ldur", 32'hF84402C9, 64'h1234, 1'b0);
        check("ldur.sext_lit", sign_extended_output, 64'h40);
`ifdef REGFILE_INIT_EN
        check("ldur.rd1_lit", read_data1, 64'd22);
        check("ldur.rd2_lit", read_data2, 64'd4);
`endif
        // ADD X10,X19,X9 sees the new X9
        step("add", rtype(11'b10001011000, 5'd9, 5'd19, 5'd10), 64'h5555, 1'b0);
        check("add.rd2_lit", read_data2, 64'h1234);

        // STUR X11,[X22,#96] must not write X11
        step("stur", dtype(11'b11111000000, 9'd96, 5'd22, 5'd11), 64'hDEAD, 1'b0);
        check("stur.sext_lit", sign_extended_output, 64'h60);

        // CBZ X11,-5 (also re-reads X11 after the store edge)
        step("cbz", {8'b10110100, 19'h7FFFB, 5'd11}, 64'hBEEF, 1'b0);
        check("cbz.sext_lit", sign_extended_output, 64'hFFFFFFFFFFFFFFFB);

        // B -55
        ins = {6'b000101, 26'h3FFFFC9};
        step("b", ins, 64'hBEEF, 1'b0);
        check("b.sext_lit", sign_extended_output, 64'hFFFFFFFFFFFFFFC9);

        // Write to XZR is discarded
        step("xzr_wr", rtype(11'b10001011000, 5'd2, 5'd1, 5'd31), 64'hFF, 1'b0);
        step("xzr_rd", {11'd0, 5'd31, 6'd0, 5'd31, 5'd0}, 64'd0, 1'b0);
        check("xzr_rd.lit", read_data1, 64'd0);

        // Reset overrides a simultaneous write to X10
        step("rst_wr", rtype(11'b10001011000, 5'd2, 5'd1, 5'd10), 64'hABC, 1'b1);
        step("rst_rd", {11'd0, 5'd10, 6'd0, 5'd10, 5'd0}, 64'd0, 1'b0);
        check("rst_rd.lit", read_data1, reset_val(10));

        // Randomized traffic with occasional resets
        for (int k = 0; k < 300; k++) begin
            step("rand", rand_instr(), {$urandom, $urandom},
                 ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i_decode.md
I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 SHALL have parameter INSTR_LEN, default 32: instruction width in bits.
REQ-002 SHALL have parameter WORD, default 64: data and register width in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port instruction_in, input, INSTR_LEN bits: the LEGv8 instruction being decoded.
REQ-007 SHALL have port write_data_in, input, WORD bits: register write-back data.
REQ-008 SHALL have port opcode, output, 11 bits: instruction_in[31:21].
REQ-009 SHALL have port sign_extended_output, output, WORD bits: the extended immediate.
REQ-010 SHALL have outputs reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src and reg_write, each 1 bit: datapath control signals.
REQ-011 SHALL have port alu_op, output, 2 bits: ALU operation class.
REQ-012 SHALL have ports read_data1 and read_data2, output, WORD bits each: register-file read ports.

Function
REQ-013 SHALL make all outputs combinational from instruction_in and register contents (zero-cycle latency).
REQ-014 SHALL drive control outputs as follows (all unlisted bits are 0):
- R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: reg_write=1, alu_op=10.
- LDUR 11111000010: alu_src, mem_to_reg, reg_write and mem_read = 1, alu_op=00.
- STUR 11111000000: reg2_loc, alu_src and mem_write = 1, alu_op=00.
- CBZ, opcode[10:3]=10110100: reg2_loc and branch = 1, alu_op=01.
- B, opcode[10:5]=000101: uncondbranch=1.
- Any other opcode: all controls 0.
REQ-015 SHALL drive sign_extended_output by instruction type:
- LDUR/STUR: sign-extend instruction_in[20:12].
- CBZ: sign-extend instruction_in[23:5].
- B: sign-extend instruction_in[25:0].
- R-type and unknown opcodes: 0.
REQ-016 SHALL contain a register file of 32 registers, each WORD bits wide.
REQ-017 SHALL drive read_data1 from the register at instruction_in[9:5].
REQ-018 SHALL drive read_data2 from the register at instruction_in[4:0] when reg2_loc=1, otherwise from instruction_in[20:16].
REQ-019 SHALL return 0 for any read of X31 (XZR), regardless of writes.
REQ-020 SHALL, on a rising clk edge with reg_write=1 and reset=0, write write_data_in to the register at instruction_in[4:0]; writes to X31 are discarded.
REQ-021 SHALL show the old register value on reads until the write edge and the new value immediately after it; there is no bypass.

Reset
REQ-022 SHALL, on a rising clk edge with reset=1, initialise all registers (see REQ-024/REQ-025); reset overrides any simultaneous write.
REQ-023 SHALL keep decode outputs purely combinational, so they are unaffected by reset.

Configuration
REQ-024 SHALL, when macro REGFILE_INIT_EN is defined, make reset load register Xn with the value n (n = 0..30).
REQ-025 SHALL, when REGFILE_INIT_EN is undefined, make reset clear all registers to 0.

Verification (REGFILE_INIT_EN defined, after reset)
REQ-026 SHALL cover LDUR X9,[X22,#64], instruction 32'hF84402C9 -> opcode 11111000010, sign_extended_output 64'h40, read_data1=22, read_data2=4, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00; then write_data_in=64'h1234 at the edge -> X9 reads 64'h1234.
REQ-027 SHALL cover ADD X10,X19,X9 -> read_data1=19, read_data2=64'h1234, reg_write=1, alu_op=10, sign_extended_output 0.
REQ-028 SHALL cover STUR X11,[X22,#96] -> reg2_loc=1, mem_write=1, reg_write=0, sign_extended_output 64'h60, read_data2=X11; a clock edge leaves X11 unchanged.
REQ-029 SHALL cover CBZ X11,-5 -> branch=1, alu_op=01, sign_extended_output 64'hFFFFFFFFFFFFFFFB; and B -55 -> uncondbranch=1, sign_extended_output 64'hFFFFFFFFFFFFFFC9.
REQ-030 SHALL cover an attempted write of 64'hFF to X31 -> read of X31 returns 0; and reset asserted together with a write -> the target register holds its reset value.
